// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op codes,
// forward-select encodings and the EX/MEM register layout.
package ex_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11,
    OP_MUL  = 4'd12
  } alu_op_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EX = 2'b10;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  typedef struct packed {
    logic [4:0] wr_addr;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    ctrl_t           ctrl;
  } ex_mem_t;

  // Encoding 2'b11 falls through to the register-file value.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] rf_val,
                                              input logic [XLEN-1:0] wb_val,
                                              input logic [XLEN-1:0] ex_val);
    case (sel)
      FWD_RF:  return rf_val;
      FWD_WB:  return wb_val;
      FWD_EX:  return ex_val;
      default: return rf_val;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, forwarding/hazard controls and EX/MEM outputs
// seen by the execute stage.
interface ex_stage_if import ex_stage_pkg::*; ();

  logic            id_ex_valid;
  logic [3:0]      id_ex_alu_op;
  logic [XLEN-1:0] id_ex_rs_data;
  logic [XLEN-1:0] id_ex_rt_data;
  logic [XLEN-1:0] id_ex_imm;
  logic            id_ex_alu_src;
  logic [4:0]      id_ex_wr_addr;
  logic            id_ex_RegWrite;
  logic            id_ex_MemRead;
  logic            id_ex_MemWrite;
  logic            id_ex_MemtoReg;
  logic [1:0]      ForwardA;
  logic [1:0]      ForwardB;
  logic [XLEN-1:0] wb_data;
  logic            mem_stall;
  logic            flush;

  logic            ex_busy;
  logic            ex_mem_valid;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;
  logic [4:0]      ex_mem_wr_addr;
  logic            ex_mem_RegWrite;
  logic            ex_mem_MemRead;
  logic            ex_mem_MemWrite;
  logic            ex_mem_MemtoReg;

  modport master (
    output id_ex_valid, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
           id_ex_alu_src, id_ex_wr_addr, id_ex_RegWrite, id_ex_MemRead,
           id_ex_MemWrite, id_ex_MemtoReg, ForwardA, ForwardB, wb_data,
           mem_stall, flush,
    input  ex_busy, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data,
           ex_mem_wr_addr, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite,
           ex_mem_MemtoReg
  );

  modport slave (
    input  id_ex_valid, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
           id_ex_alu_src, id_ex_wr_addr, id_ex_RegWrite, id_ex_MemRead,
           id_ex_MemWrite, id_ex_MemtoReg, ForwardA, ForwardB, wb_data,
           mem_stall, flush,
    output ex_busy, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data,
           ex_mem_wr_addr, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite,
           ex_mem_MemtoReg
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Single-cycle combinational ALU; MUL and undefined codes yield 0 here,
// multiplication is sequenced by ex_stage.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;

  always_comb begin
    shamt = b[4:0];
    y     = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $unsigned($signed(a) >>> shamt);
      OP_LUI:  y = b << 16;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, multi-cycle multiply FSM and the
// EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d;
  logic [XLEN-1:0] mul_b_q, mul_b_d;
  ctrl_t           mul_ctrl_q, mul_ctrl_d;
  ex_mem_t         ex_mem_q, ex_mem_d;

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_y, mul_lo;
  ctrl_t           id_ctrl;
  logic            is_mul, mul_entry, busy;

  ex_stage_alu u_alu (
    .op (bus.id_ex_alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  assign mul_lo = mul_a_q * mul_b_q;

  always_comb begin
    op_a    = fwd_mux(bus.ForwardA, bus.id_ex_rs_data, bus.wb_data, ex_mem_q.alu_result);
    fwd_b   = fwd_mux(bus.ForwardB, bus.id_ex_rt_data, bus.wb_data, ex_mem_q.alu_result);
    op_b    = bus.id_ex_alu_src ? bus.id_ex_imm : fwd_b;
    id_ctrl = '{wr_addr:    bus.id_ex_wr_addr,
                reg_write:  bus.id_ex_RegWrite,
                mem_read:   bus.id_ex_MemRead,
                mem_write:  bus.id_ex_MemWrite,
                mem_to_reg: bus.id_ex_MemtoReg};
    is_mul    = (bus.id_ex_alu_op == OP_MUL);
    mul_entry = bus.id_ex_valid && is_mul && !bus.flush && !bus.mem_stall;

    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_ctrl_d = mul_ctrl_q;
    ex_mem_d   = ex_mem_q;
    busy       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = mul_entry || (bus.mem_stall && bus.id_ex_valid && !bus.flush);
        if (!bus.mem_stall) begin
          // Bubbles (idle, flushed, or MUL just starting) are written as all-zero.
          ex_mem_d = '0;
          if (bus.id_ex_valid && !bus.flush) begin
            if (is_mul) begin
              state_d    = S_MUL;
              cnt_d      = CNT_W'(MUL_LAT - 1);
              mul_a_d    = op_a;
              mul_b_d    = fwd_b;
              mul_ctrl_d = id_ctrl;
            end else begin
              ex_mem_d = '{valid:      1'b1,
                           alu_result: alu_y,
                           store_data: fwd_b,
                           ctrl:       id_ctrl};
            end
          end
        end
      end
      S_MUL: begin
        busy = !bus.flush && ((cnt_q != '0) || bus.mem_stall);
        if (bus.flush) begin
          state_d = S_IDLE;
          if (!bus.mem_stall) ex_mem_d = '0;
        end else if (!bus.mem_stall) begin
          if (cnt_q != '0) begin
            cnt_d    = cnt_q - 1'b1;
            ex_mem_d = '0;
          end else begin
            state_d  = S_IDLE;
            ex_mem_d = '{valid:      1'b1,
                         alu_result: mul_lo,
                         store_data: mul_b_q,
                         ctrl:       mul_ctrl_q};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_ctrl_q <= '0;
      ex_mem_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_ctrl_q <= mul_ctrl_d;
      ex_mem_q   <= ex_mem_d;
    end
  end

  assign bus.ex_busy           = busy;
  assign bus.ex_mem_valid      = ex_mem_q.valid;
  assign bus.ex_mem_alu_result = ex_mem_q.alu_result;
  assign bus.ex_mem_store_data = ex_mem_q.store_data;
  assign bus.ex_mem_wr_addr    = ex_mem_q.ctrl.wr_addr;
  assign bus.ex_mem_RegWrite   = ex_mem_q.ctrl.reg_write;
  assign bus.ex_mem_MemRead    = ex_mem_q.ctrl.mem_read;
  assign bus.ex_mem_MemWrite   = ex_mem_q.ctrl.mem_write;
  assign bus.ex_mem_MemtoReg   = ex_mem_q.ctrl.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a front-end driver holds each instruction while
// ex_busy is high and queues its expected EX/MEM record; a monitor pops on every real write.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs, rt, imm, wb;
    logic        src;
    logic [1:0]  fa, fb;
    logic [4:0]  wa;
    logic [3:0]  ctl;   // {RegWrite, MemRead, MemWrite, MemtoReg}
  } instr_t;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  wa;
    logic [3:0]  ctl;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_ex  = '0;
  bit          last_real = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference arithmetic written directly from the op definitions.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] ones;
    logic [63:0] prod;
    int          s;
    ones = '1;
    s    = int'(b[4:0]);
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a << s;
      4'd9:  return a >> s;
      4'd10: return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      4'd11: return b * 32'd65536;
      4'd12: return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] ex);
    return (sel == 2'b01) ? wb : (sel == 2'b10) ? ex : rf;
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    instr_t i;
    i.valid = 1'b1; i.op = op; i.rs = rs; i.rt = rt; i.imm = '0; i.wb = '0;
    i.src = 1'b0; i.fa = 2'b00; i.fb = 2'b00; i.wa = 5'd3; i.ctl = 4'b1000;
    return i;
  endfunction

  task automatic drive_idle();
    bus.id_ex_valid = 1'b0; bus.id_ex_alu_op = '0; bus.id_ex_rs_data = '0;
    bus.id_ex_rt_data = '0; bus.id_ex_imm = '0; bus.id_ex_alu_src = 1'b0;
    bus.id_ex_wr_addr = '0; bus.id_ex_RegWrite = 1'b0; bus.id_ex_MemRead = 1'b0;
    bus.id_ex_MemWrite = 1'b0; bus.id_ex_MemtoReg = 1'b0; bus.ForwardA = '0;
    bus.ForwardB = '0; bus.wb_data = '0; bus.mem_stall = 1'b0; bus.flush = 1'b0;
  endtask

  // Present one instruction in ID/EX until an edge with ex_busy low takes it.
  task automatic issue(input instr_t in, input int flush_cyc, input logic [7:0] stall_mask,
                       output int cycles, output int busy_cycles);
    logic [31:0] a, fb_v, b, res;
    bit          done, flushed, busy_seen;
    exp_t        e;
    a    = pick(in.fa, in.rs, in.wb, last_ex);
    fb_v = pick(in.fb, in.rt, in.wb, last_ex);
    b    = in.src ? in.imm : fb_v;
    res  = (in.op == 4'd12) ? ref_op(in.op, a, fb_v) : ref_op(in.op, a, b);
    cycles = 0; busy_cycles = 0; done = 1'b0; flushed = 1'b0;
    while (!done) begin
      @(negedge clk);
      bus.id_ex_valid = in.valid; bus.id_ex_alu_op = in.op; bus.id_ex_rs_data = in.rs;
      bus.id_ex_rt_data = in.rt; bus.id_ex_imm = in.imm; bus.id_ex_alu_src = in.src;
      bus.id_ex_wr_addr = in.wa; {bus.id_ex_RegWrite, bus.id_ex_MemRead,
      bus.id_ex_MemWrite, bus.id_ex_MemtoReg} = in.ctl;
      bus.ForwardA = in.fa; bus.ForwardB = in.fb; bus.wb_data = in.wb;
      bus.mem_stall = (cycles < 8) ? stall_mask[cycles] : 1'b0;
      bus.flush = (cycles == flush_cyc);
      if (cycles == flush_cyc) flushed = 1'b1;
      #4;
      busy_seen = bus.ex_busy;
      if (busy_seen) busy_cycles++;
      @(posedge clk);
      cycles++;
      if (!busy_seen) done = 1'b1;
      if (cycles >= 200) begin
        check("issue_timeout", 32'(cycles), 32'd0);
        done = 1'b1;
      end
    end
    if (in.valid && !flushed) begin
      e.result = res; e.store = fb_v; e.wa = in.wa; e.ctl = in.ctl;
      exp_q.push_back(e);
      last_ex = res; last_real = 1'b1;
    end else begin
      last_real = 1'b0;
    end
  endtask

  // Monitor: a real EX/MEM write is a non-stalled, out-of-reset edge leaving valid high.
  initial begin
    bit   stall_at, rst_at;
    exp_t e;
    forever begin
      @(posedge clk);
      stall_at = bus.mem_stall;
      rst_at   = rst_n;
      #1;
      if (!bus.ex_mem_valid) begin
        check("bubble_ctrl", {28'd0, bus.ex_mem_RegWrite, bus.ex_mem_MemRead,
                              bus.ex_mem_MemWrite, bus.ex_mem_MemtoReg}, 32'd0);
      end else if (rst_at && !stall_at) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", bus.ex_mem_alu_result, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("alu_result", bus.ex_mem_alu_result, e.result);
          check("store_data", bus.ex_mem_store_data, e.store);
          check("wr_addr", {27'd0, bus.ex_mem_wr_addr}, {27'd0, e.wa});
          check("ctrl", {28'd0, bus.ex_mem_RegWrite, bus.ex_mem_MemRead,
                         bus.ex_mem_MemWrite, bus.ex_mem_MemtoReg}, {28'd0, e.ctl});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus.ex_mem_valid}, 32'd0);
    check({tag, "_result"}, bus.ex_mem_alu_result, 32'd0);
    check({tag, "_store"}, bus.ex_mem_store_data, 32'd0);
    check({tag, "_wa"}, {27'd0, bus.ex_mem_wr_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.ex_busy}, 32'd0);
  endtask

  initial begin
    instr_t in;
    int     cyc, bcyc, fl;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // ADD 5+7
    in = mk(4'd0, 32'd5, 32'd7);
    issue(in, 99, 8'h00, cyc, bcyc);
    #1;
    check("add_latency", 32'(cyc), 32'd1);
    check("add_result", bus.ex_mem_alu_result, 32'd12);
    check("add_regwrite", {31'd0, bus.ex_mem_RegWrite}, 32'd1);

    // Dependent ADD through EX/MEM forward plus immediate
    in = mk(4'd0, 32'd100, 32'd0); in.fa = 2'b10; in.src = 1'b1; in.imm = 32'd3;
    issue(in, 99, 8'h00, cyc, bcyc);
    #1 check("fwd_ex_add", bus.ex_mem_alu_result, 32'd15);

    // Store with rt forwarded from WB
    in = mk(4'd0, 32'd20, 32'd1); in.fb = 2'b01; in.wb = 32'd9; in.src = 1'b1;
    in.imm = 32'd4; in.ctl = 4'b0010;
    issue(in, 99, 8'h00, cyc, bcyc);
    #1 check("fwd_wb_store", bus.ex_mem_store_data, 32'd9);

    // MUL 6*7
    in = mk(4'd12, 32'd6, 32'd7);
    issue(in, 99, 8'h00, cyc, bcyc);
    #1;
    check("mul_busy_cycles", 32'(bcyc), 32'(MUL_LAT));
    check("mul_latency", 32'(cyc), 32'(MUL_LAT + 1));
    check("mul_result", bus.ex_mem_alu_result, 32'd42);

    in = mk(4'd12, 32'hFFFF_FFFF, 32'd2);
    issue(in, 99, 8'h00, cyc, bcyc);
    #1 check("mul_wrap", bus.ex_mem_alu_result, 32'hFFFF_FFFE);

    // Two stall cycles mid-multiply delay completion by exactly two
    in = mk(4'd12, 32'd11, 32'd13);
    issue(in, 99, 8'b0000_1100, cyc, bcyc);
    #1;
    check("mul_stall_latency", 32'(cyc), 32'(MUL_LAT + 3));
    check("mul_stall_result", bus.ex_mem_alu_result, 32'd143);

    // Flush with cnt==2: busy drops in the flush cycle, nothing written
    in = mk(4'd12, 32'd3, 32'd5);
    issue(in, 2, 8'h00, cyc, bcyc);
    check("mul_flush_cycles", 32'(cyc), 32'd3);
    check("mul_flush_busy", 32'(bcyc), 32'd2);
    @(negedge clk) drive_idle();
    repeat (MUL_LAT + 2) @(posedge clk);
    #1 check("mul_flush_no_result", {31'd0, bus.ex_mem_valid}, 32'd0);

    // Shifts and compares
    in = mk(4'd10, 32'h8000_0000, 32'd0); in.src = 1'b1; in.imm = 32'd4;
    issue(in, 99, 8'h00, cyc, bcyc);
    #1 check("sra", bus.ex_mem_alu_result, 32'hF800_0000);
    in = mk(4'd6, 32'hFFFF_FFFF, 32'd1);
    issue(in, 99, 8'h00, cyc, bcyc);
    #1 check("slt", bus.ex_mem_alu_result, 32'd1);
    in = mk(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(in, 99, 8'h00, cyc, bcyc);
    #1 check("sltu", bus.ex_mem_alu_result, 32'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.id_ex_valid = 1'b1; bus.id_ex_alu_op = 4'd12; bus.id_ex_rs_data = 32'd9;
    bus.id_ex_rt_data = 32'd9; bus.id_ex_RegWrite = 1'b1; bus.id_ex_wr_addr = 5'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1 check_all_zero("mid_mul_reset");
    @(negedge clk) rst_n = 1'b1;
    last_real = 1'b0;
    repeat (MUL_LAT + 2) @(posedge clk);
    #1 check("mid_mul_reset_no_result", {31'd0, bus.ex_mem_valid}, 32'd0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 80; n++) begin
      in.valid = ($urandom_range(0, 7) != 0);
      in.op    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) in.op = 4'd12;
      in.rs    = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      in.rt    = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      in.imm   = $urandom;
      in.wb    = $urandom;
      in.src   = 1'($urandom_range(0, 1));
      in.fa    = 2'($urandom_range(0, 3));
      in.fb    = 2'($urandom_range(0, 3));
      if (!last_real && in.fa == 2'b10) in.fa = 2'b00;
      if (!last_real && in.fb == 2'b10) in.fb = 2'b11;
      in.wa    = 5'($urandom_range(0, 31));
      in.ctl   = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 5) : 99;
      issue(in, fl, 8'($urandom_range(0, 15)), cyc, bcyc);
    end

    @(negedge clk) drive_idle();
    repeat (MUL_LAT + 2) @(posedge clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
